// File: rtl/pe_mac_chain.sv
// ---------------------------------------------------------------------------
// pe_mac_chain
//
// Multiply-accumulate processing element for the LeNet convolution PE array.
// Each window sums cfg_len products (imap * iweight) onto an aligned bias.
// The sum is then rounded half-up, optionally clamped by ReLU, and saturated
// to DATA_W bits. The finished word joins a daisy-chained result bus that it
// shares with upstream PEs. An own result that collides with upstream traffic
// is parked in a one-entry hold buffer instead of being lost.
//
// Ports
//   clk_cal              : single clock, rising edge
//   rst_cal              : asynchronous active-high reset
//   cfg_len / cfg_relu   : products per window (0 acts as 1) / ReLU enable,
//                          sampled at the first MAC of a window
//   bias                 : bias word, sampled at the first MAC of a window
//   imap, imap_vld       : map operand and its valid
//   iweight, iweight_vld : weight operand and its valid
//   din, din_vld         : result word from the upstream PE
//   dout, dout_vld       : chain output, one-cycle valid per word
//   dout_ovf             : own word on dout was saturated
//   nmap, nmap_vld       : map forwarded to the neighbouring PE
//   busy                 : a window is partially accumulated
//   err_drop             : sticky, an own result was dropped
// ---------------------------------------------------------------------------
module pe_mac_chain #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 3,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 10
) (
    input  logic              clk_cal,
    input  logic              rst_cal,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              cfg_relu,
    input  logic [DATA_W-1:0] bias,
    input  logic [DATA_W-1:0] imap,
    input  logic              imap_vld,
    input  logic [DATA_W-1:0] iweight,
    input  logic              iweight_vld,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              dout_ovf,
    output logic [DATA_W-1:0] nmap,
    output logic              nmap_vld,
    output logic              busy,
    output logic              err_drop
);

    localparam int PROD_W = 2 * DATA_W;

    // The constants below live at ACC_W+1 bits, so adding the rounding
    // offset can never wrap the accumulator value.
    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) <<< (FRAC_W - 1);
    localparam logic signed [ACC_W:0] SAT_MAX  =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN  =
        {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                     mac_en;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_aligned;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    rnd_shr;
    logic signed [ACC_W:0]    relu_val;
    logic [DATA_W-1:0]        sat_val;
    logic                     sat_ovf;

    logic [CNT_W-1:0]         cnt_reg;
    logic [CNT_W-1:0]         len_reg;
    logic                     relu_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]         len_cfg;
    logic [CNT_W-1:0]         len_eff;
    logic                     relu_eff;
    logic                     win_first;
    logic                     win_last;

    assign mac_en = imap_vld & iweight_vld;

    // Sign-extending both operands to the product width keeps the multiply
    // width-matched; the low PROD_W bits are the exact signed product.
    assign product  = $signed({{DATA_W{imap[DATA_W-1]}}, imap}) *
                      $signed({{DATA_W{iweight[DATA_W-1]}}, iweight});
    assign prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

    // The bias has FRAC_W fraction bits and the product has 2*FRAC_W.
    // Shifting the bias left by FRAC_W puts both on the same binary point.
    assign bias_aligned = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};

    // During the first MAC of a window the live configuration applies. A
    // one-tap window finishes in that same cycle. After that the latched
    // copies are used, so mid-window cfg changes are ignored. The bias
    // needs no register of its own: it is folded into acc at the first MAC.
    assign win_first = (cnt_reg == '0);
    assign len_cfg   = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
    assign len_eff   = win_first ? len_cfg  : len_reg;
    assign relu_eff  = win_first ? cfg_relu : relu_reg;
    assign win_last  = (cnt_reg == len_eff - CNT_W'(1));

    assign acc_base = win_first ? bias_aligned : acc_reg;
    assign acc_sum  = acc_base + prod_ext;

    assign rnd_sum  = $signed({acc_sum[ACC_W-1], acc_sum}) + RND_HALF;
    assign rnd_shr  = rnd_sum >>> FRAC_W;
    assign relu_val = (relu_eff && rnd_shr[ACC_W]) ? '0 : rnd_shr;

    always_comb begin
        sat_val = relu_val[DATA_W-1:0];
        sat_ovf = 1'b0;
        if (relu_val > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
            sat_ovf = 1'b1;
        end else if (relu_val < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
            sat_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            cnt_reg  <= '0;
            len_reg  <= CNT_W'(1);
            relu_reg <= 1'b0;
            acc_reg  <= '0;
        end else if (mac_en) begin
            if (win_first) begin
                len_reg  <= len_cfg;
                relu_reg <= cfg_relu;
            end
            if (win_last) begin
                cnt_reg <= '0;
                acc_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                acc_reg <= acc_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result stage, hold buffer and chain arbitration
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] res_reg;
    logic              res_vld_reg;
    logic              res_ovf_reg;
    logic [DATA_W-1:0] hold_reg,     hold_next;
    logic              hold_vld_reg, hold_vld_next;
    logic              hold_ovf_reg, hold_ovf_next;
    logic [DATA_W-1:0] dout_reg,     dout_next;
    logic              dout_vld_reg, dout_vld_next;
    logic              dout_ovf_reg, dout_ovf_next;
    logic [DATA_W-1:0] nmap_reg;
    logic              nmap_vld_reg;
    logic              err_drop_reg;
    logic              drop_now;

    // Upstream words always win the bus. Own results queue behind them in
    // age order: the hold buffer is older than res, so it goes first. A
    // third result that finds both slots taken is the one that gets dropped.
    always_comb begin
        dout_next     = dout_reg;
        dout_vld_next = 1'b0;
        dout_ovf_next = 1'b0;
        hold_next     = hold_reg;
        hold_vld_next = hold_vld_reg;
        hold_ovf_next = hold_ovf_reg;
        drop_now      = 1'b0;
        if (din_vld) begin
            dout_next     = din;
            dout_vld_next = 1'b1;
            if (res_vld_reg) begin
                if (hold_vld_reg) begin
                    drop_now = 1'b1;
                end else begin
                    hold_next     = res_reg;
                    hold_ovf_next = res_ovf_reg;
                    hold_vld_next = 1'b1;
                end
            end
        end else if (hold_vld_reg) begin
            dout_next     = hold_reg;
            dout_vld_next = 1'b1;
            dout_ovf_next = hold_ovf_reg;
            // The hold slot is freed and immediately refilled by res, if any.
            hold_next     = res_reg;
            hold_ovf_next = res_ovf_reg;
            hold_vld_next = res_vld_reg;
        end else if (res_vld_reg) begin
            dout_next     = res_reg;
            dout_vld_next = 1'b1;
            dout_ovf_next = res_ovf_reg;
        end
    end

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            res_reg      <= '0;
            res_vld_reg  <= 1'b0;
            res_ovf_reg  <= 1'b0;
            hold_reg     <= '0;
            hold_vld_reg <= 1'b0;
            hold_ovf_reg <= 1'b0;
            dout_reg     <= '0;
            dout_vld_reg <= 1'b0;
            dout_ovf_reg <= 1'b0;
            nmap_reg     <= '0;
            nmap_vld_reg <= 1'b0;
            err_drop_reg <= 1'b0;
        end else begin
            res_vld_reg <= mac_en & win_last;
            if (mac_en && win_last) begin
                res_reg     <= sat_val;
                res_ovf_reg <= sat_ovf;
            end
            hold_reg     <= hold_next;
            hold_vld_reg <= hold_vld_next;
            hold_ovf_reg <= hold_ovf_next;
            dout_reg     <= dout_next;
            dout_vld_reg <= dout_vld_next;
            dout_ovf_reg <= dout_ovf_next;
            nmap_vld_reg <= mac_en;
            if (mac_en) begin
                nmap_reg <= imap;
            end
            if (drop_now) begin
                err_drop_reg <= 1'b1;
            end
        end
    end

    assign dout     = dout_reg;
    assign dout_vld = dout_vld_reg;
    assign dout_ovf = dout_ovf_reg;
    assign nmap     = nmap_reg;
    assign nmap_vld = nmap_vld_reg;
    assign busy     = (cnt_reg != '0);
    assign err_drop = err_drop_reg;

endmodule

// File: tb/tb_pe_mac_chain.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_chain
//
// Bench for pe_mac_chain with DATA_W=8, FRAC_W=3, ACC_W=24 (1.0 = 8).
//
// A behavioural model tracks each window as a plain integer sum. When a
// window closes, the model post-processes the sum with integer floor
// arithmetic. Own results that wait for the bus sit in a queue. Each scenario
// task drives stimulus and compares DUT outputs to the model every cycle. It
// also checks the fixed values expected for that scenario.
// ---------------------------------------------------------------------------
module tb_pe_mac_chain;

    logic       clk_cal = 1'b0;
    logic       rst_cal = 1'b1;
    logic [9:0] cfg_len = '0;
    logic       cfg_relu = 1'b0;
    logic [7:0] bias = '0;
    logic [7:0] imap = '0;
    logic       imap_vld = 1'b0;
    logic [7:0] iweight = '0;
    logic       iweight_vld = 1'b0;
    logic [7:0] din = '0;
    logic       din_vld = 1'b0;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_ovf;
    logic [7:0] nmap;
    logic       nmap_vld;
    logic       busy;
    logic       err_drop;

    int checks = 0;
    int errors = 0;

    pe_mac_chain #(.DATA_W(8), .FRAC_W(3), .ACC_W(24), .CNT_W(10)) dut (
        .clk_cal(clk_cal), .rst_cal(rst_cal),
        .cfg_len(cfg_len), .cfg_relu(cfg_relu), .bias(bias),
        .imap(imap), .imap_vld(imap_vld),
        .iweight(iweight), .iweight_vld(iweight_vld),
        .din(din), .din_vld(din_vld),
        .dout(dout), .dout_vld(dout_vld), .dout_ovf(dout_ovf),
        .nmap(nmap), .nmap_vld(nmap_vld),
        .busy(busy), .err_drop(err_drop)
    );

    always #5 clk_cal = ~clk_cal;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [7:0] e_dout;
    logic       e_vld, e_ovf, e_nmap_vld, e_busy, e_err;
    logic [7:0] e_nmap;
    logic [8:0] pend[$];      // own results waiting for the bus, {ovf, value}
    logic [8:0] m_res;
    logic       m_res_vld;
    int         taps, w_len, w_sum;
    bit         w_relu;

    // Takes a sum with 6 fraction bits. Returns {ovf, word} with 3 fraction bits.
    function automatic logic [8:0] post(input int s, input bit relu);
        int r;
        r = s + 4;
        r = (r >= 0) ? r / 8 : -((-r + 7) / 8);
        if (relu && r < 0) r = 0;
        if (r > 127) return {1'b1, 8'h7F};
        if (r < -128) return {1'b1, 8'h80};
        return {1'b0, r[7:0]};
    endfunction

    always @(posedge clk_cal or posedge rst_cal) begin
        if (rst_cal) begin
            e_dout = '0; e_vld = 0; e_ovf = 0; e_nmap = '0; e_nmap_vld = 0;
            e_busy = 0; e_err = 0; pend.delete(); m_res = '0; m_res_vld = 0;
            taps = 0; w_sum = 0; w_len = 1; w_relu = 0;
        end else begin
            // A result completed last cycle is offered to the bus this cycle.
            e_vld = 0;
            e_ovf = 0;
            if (din_vld) begin
                e_vld  = 1;
                e_dout = din;
                if (m_res_vld) begin
                    if (pend.size() > 0) e_err = 1;
                    else pend.push_back(m_res);
                end
            end else if (pend.size() > 0) begin
                {e_ovf, e_dout} = pend.pop_front();
                e_vld = 1;
                if (m_res_vld) pend.push_back(m_res);
            end else if (m_res_vld) begin
                {e_ovf, e_dout} = m_res;
                e_vld = 1;
            end
            m_res_vld  = 0;
            e_nmap_vld = 0;
            if (imap_vld && iweight_vld) begin
                e_nmap     = imap;
                e_nmap_vld = 1;
                if (taps == 0) begin
                    w_len  = (cfg_len == 0) ? 1 : int'(cfg_len);
                    w_relu = cfg_relu;
                    w_sum  = $signed(bias) * 8;
                end
                w_sum += $signed(imap) * $signed(iweight);
                taps++;
                if (taps == w_len) begin
                    m_res     = post(w_sum, w_relu);
                    m_res_vld = 1;
                    taps      = 0;
                end
            end
            e_busy = (taps != 0);
        end
    end

    wire [20:0] obs_vec = {dout_vld, dout_vld ? dout : 8'h00, dout_vld & dout_ovf,
                           nmap_vld, nmap, busy, err_drop};
    wire [20:0] exp_vec = {e_vld, e_vld ? e_dout : 8'h00, e_vld & e_ovf,
                           e_nmap_vld, e_nmap, e_busy, e_err};

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_cal);
        #1;
    endtask

    task automatic set_mac(input logic [7:0] m, input logic [7:0] w, input logic v);
        imap = m; iweight = w; imap_vld = v; iweight_vld = v;
    endtask

    task automatic do_reset();
        set_mac(8'h00, 8'h00, 1'b0);
        din_vld = 0;
        rst_cal = 1;
        tick();
        rst_cal = 0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_cal = 1;
        tick();
        tick();
        checks++;
        if ({dout, dout_vld, dout_ovf, nmap, nmap_vld, busy, err_drop} !== 21'd0) begin
            errors++;
            $display("FAIL reset_values got=%h exp=0",
                     {dout, dout_vld, dout_ovf, nmap, nmap_vld, busy, err_drop});
        end
        rst_cal = 0;
        tick();
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_basic();
        int busy_cycles = 0;
        int pulses = 0;
        int lat = -1;
        logic [8:0] word = '0;
        do_reset();
        cfg_len = 3; cfg_relu = 0; bias = 8'd8;
        for (int i = 0; i < 9; i++) begin
            if (i < 3) set_mac(8'd16, 8'd8, 1'b1);
            else       set_mac(8'd0, 8'd0, 1'b0);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (busy) busy_cycles++;
            if (dout_vld) begin
                pulses++;
                word = {dout_ovf, dout};
                if (lat < 0) lat = i - 2;
            end
        end
        checks++;
        if (pulses !== 1 || word !== {1'b0, 8'd56} || lat !== 1) begin
            errors++;
            $display("FAIL basic_result got pulses=%0d word=%h lat=%0d exp 1 038 1",
                     pulses, word, lat);
        end
        checks++;
        if (busy_cycles !== 2) begin
            errors++;
            $display("FAIL basic_busy got=%0d exp=2", busy_cycles);
        end
    endtask

    task automatic test_round_relu();
        logic [7:0] mv[4] = '{8'd4, 8'd3, 8'hF0, 8'hF0};
        logic [7:0] wv[4] = '{8'd1, 8'd1, 8'd8, 8'd8};
        bit         rv[4] = '{0, 0, 0, 1};
        logic [7:0] expv[4] = '{8'h01, 8'h00, 8'hF0, 8'h00};
        logic [7:0] seq[$];
        do_reset();
        cfg_len = 1; bias = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                set_mac(mv[i], wv[i], 1'b1);
                cfg_relu = rv[i];
            end else begin
                set_mac(8'd0, 8'd0, 1'b0);
            end
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL round_relu cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (i < 4 && busy !== 1'b0) begin
                errors++;
                $display("FAIL round_relu_busy cyc=%0d got=1 exp=0", i);
            end
            if (dout_vld) seq.push_back(dout);
        end
        checks++;
        if (seq.size() !== 4) begin
            errors++;
            $display("FAIL round_relu_count got=%0d exp=4", seq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (seq[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL round_relu_word%0d got=%h exp=%h", k, seq[k], expv[k]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [8:0] seq[$];
        do_reset();
        cfg_len = 25; cfg_relu = 0; bias = 0;
        for (int i = 0; i < 54; i++) begin
            if (i < 25)      set_mac(8'd127, 8'd127, 1'b1);
            else if (i < 50) set_mac(8'h80, 8'd127, 1'b1);
            else             set_mac(8'd0, 8'd0, 1'b0);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL saturation cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (dout_vld) seq.push_back({dout_ovf, dout});
        end
        checks++;
        if (seq.size() !== 2 || seq[0] !== {1'b1, 8'h7F} || seq[1] !== {1'b1, 8'h80}) begin
            errors++;
            $display("FAIL saturation_words got n=%0d w0=%h w1=%h exp n=2 17f 180",
                     seq.size(), seq.size() > 0 ? seq[0] : 9'h0,
                     seq.size() > 1 ? seq[1] : 9'h0);
        end
    endtask

    task automatic test_collision();
        logic [7:0] seq[$];
        do_reset();
        cfg_len = 1; cfg_relu = 0; bias = 0; din = 8'h55;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) set_mac(8'd8, 8'd8, 1'b1);
            else        set_mac(8'd0, 8'd0, 1'b0);
            din_vld = (i < 3);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL collision cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (dout_vld) seq.push_back(dout);
        end
        din_vld = 0;
        checks++;
        if (seq.size() !== 4 || seq[0] !== 8'h55 || seq[1] !== 8'h55 ||
            seq[2] !== 8'h55 || seq[3] !== 8'h08 || err_drop !== 1'b0) begin
            errors++;
            $display("FAIL collision_seq got n=%0d last=%h err=%b exp n=4 last=08 err=0",
                     seq.size(), seq.size() > 0 ? seq[seq.size()-1] : 8'h0, err_drop);
        end
    endtask

    task automatic test_hold_overflow();
        logic [7:0] seq[$];
        do_reset();
        cfg_len = 1; cfg_relu = 0; bias = 0; din = 8'h55;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) set_mac(8'(i + 1), 8'd8, 1'b1);
            else       set_mac(8'd0, 8'd0, 1'b0);
            din_vld = (i >= 1 && i <= 4);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL hold_ovf cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (dout_vld) seq.push_back(dout);
        end
        din_vld = 0;
        checks++;
        if (seq.size() < 5 || seq[3] !== 8'h55 || seq[4] !== 8'h01 || err_drop !== 1'b1) begin
            errors++;
            $display("FAIL hold_ovf_first got n=%0d w4=%h err=%b exp w4=01 err=1",
                     seq.size(), seq.size() > 4 ? seq[4] : 8'h0, err_drop);
        end
        rst_cal = 1;
        tick();
        checks++;
        if (err_drop !== 1'b0) begin
            errors++;
            $display("FAIL hold_ovf_clear got=%b exp=0", err_drop);
        end
        rst_cal = 0;
        tick();
    endtask

    task automatic test_gaps_reset();
        logic [7:0] mv[5];
        logic [7:0] wv[5];
        logic [7:0] r_contig = '0;
        logic [7:0] r_gap = '0;
        int n_contig = 0;
        int n_gap = 0;
        do_reset();
        cfg_len = 5; cfg_relu = 0; bias = 8'($urandom_range(0, 255));
        for (int k = 0; k < 5; k++) begin
            mv[k] = 8'($urandom_range(0, 255));
            wv[k] = 8'($urandom_range(0, 255));
        end
        // Contiguous taps.
        for (int i = 0; i < 9; i++) begin
            if (i < 5) set_mac(mv[i], wv[i], 1'b1);
            else       set_mac(8'd0, 8'd0, 1'b0);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL gaps_contig cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (dout_vld) begin r_contig = dout; n_contig++; end
        end
        // Same taps with an idle cycle after each one.
        for (int i = 0; i < 14; i++) begin
            if (i < 10 && i % 2 == 0) set_mac(mv[i/2], wv[i/2], 1'b1);
            else                      set_mac(8'd0, 8'd0, 1'b0);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL gaps_toggle cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (dout_vld) begin r_gap = dout; n_gap++; end
        end
        checks++;
        if (n_contig !== 1 || n_gap !== 1 || r_gap !== r_contig) begin
            errors++;
            $display("FAIL gaps_equal got n=%0d/%0d gap=%h exp n=1/1 gap=%h",
                     n_contig, n_gap, r_gap, r_contig);
        end
        // Reset after three taps discards the partial sum.
        for (int i = 0; i < 3; i++) begin
            set_mac(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            tick();
        end
        set_mac(8'd0, 8'd0, 1'b0);
        rst_cal = 1;
        tick();
        checks++;
        if ({dout, dout_vld, dout_ovf, nmap, nmap_vld, busy, err_drop} !== 21'd0) begin
            errors++;
            $display("FAIL gaps_midreset got=%h exp=0",
                     {dout, dout_vld, dout_ovf, nmap, nmap_vld, busy, err_drop});
        end
        rst_cal = 0;
        tick();
        for (int i = 0; i < 9; i++) begin
            if (i < 5) set_mac(mv[4-i], wv[i], 1'b1);
            else       set_mac(8'd0, 8'd0, 1'b0);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL gaps_after_reset cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cfg_len     = 10'($urandom_range(0, 6));
            cfg_relu    = 1'($urandom_range(0, 1));
            bias        = 8'($urandom_range(0, 255));
            imap        = 8'($urandom_range(0, 255));
            iweight     = 8'($urandom_range(0, 255));
            imap_vld    = ($urandom_range(0, 3) != 0);
            iweight_vld = ($urandom_range(0, 3) != 0);
            din         = 8'($urandom_range(0, 255));
            din_vld     = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
        end
        set_mac(8'd0, 8'd0, 1'b0);
        din_vld = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_relu();
        test_saturation();
        test_collision();
        test_hold_overflow();
        test_gaps_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_mac_chain.md
# pe_mac_chain

Parametrised multiply-accumulate processing element for the LeNet convolution PE array: the successor to the fixed 8-bit, fixed-25-tap pass-through PE. Accumulates a runtime-configurable number of `imap × iweight` products onto a bias, then rounds, optionally applies ReLU and saturates. Forwards the input map to the next PE and shares a daisy-chained result bus with upstream PEs. Unlike the previous PE, it never loses its own result when an upstream word collides with it, and it reports saturation.

## Interface
Parameters:
- `DATA_W`, 8: width of map, weight, bias and output words (two's complement).
- `FRAC_W`, 3: fractional bits of every DATA_W word; must satisfy 1 ≤ FRAC_W < DATA_W.
- `ACC_W`, 24: accumulator width; must be ≥ 2*DATA_W + 4.
- `CNT_W`, 10: width of the tap counter and `cfg_len`.

Ports:
- `clk_cal` in 1: the single clock; all state on its rising edge.
- `rst_cal` in 1: asynchronous, active-high reset.
- `cfg_len` in CNT_W: products per output; sampled at the first MAC of a window; 0 is treated as 1.
- `cfg_relu` in 1: 1 = clamp negative results to 0; sampled with `cfg_len`.
- `bias` in DATA_W: sampled at the first MAC of a window.
- `imap`, `iweight` in DATA_W: operands.
- `imap_vld`, `iweight_vld` in 1: a MAC occurs only when both are high (`mac_en`).
- `din` in DATA_W, `din_vld` in 1: result word from the upstream PE.
- `dout` out DATA_W, `dout_vld` out 1: chain output, one-cycle valid per word.
- `dout_ovf` out 1: qualifies `dout_vld`; high when the word is this PE's own result and was saturated.
- `nmap` out DATA_W, `nmap_vld` out 1: forwarded map to the neighbouring PE.
- `busy` out 1: a window is partially accumulated (tap count ≠ 0).
- `err_drop` out 1: sticky; set when an own result is dropped.

## Operation
- **Formats:** product is 2*DATA_W bits with 2*FRAC_W fraction bits. Bias is aligned by sign-extending and shifting left by FRAC_W.
- **Window:** a tap counter `cnt` counts `mac_en` cycles.
  - At `cnt==0`: `acc_next = bias_aligned + product`, and `len`, `relu` and the bias are latched.
  - Otherwise: `acc_next = acc + product`.
  - Cycles with `mac_en` low hold all state, so gaps are allowed.
- **Window end:** on the MAC with `cnt == len-1`, `cnt` returns to 0, `acc` clears, and `acc_next` goes to post-processing.
- **Post-processing** (registered into a result stage `res`/`res_vld`/`res_ovf`), in order:
  1. Round half-up: `r = (acc_next + 2^(FRAC_W-1)) >>> FRAC_W` (arithmetic shift).
  2. If `relu` and `r < 0`, then `r = 0`.
  3. Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; `res_ovf = 1` if clipping occurred.
- **Map forwarding:** on each `mac_en` cycle, `nmap <= imap` and `nmap_vld <= 1`; otherwise `nmap_vld <= 0` and `nmap` holds.
- **Output arbitration, evaluated each cycle:**
  - If `din_vld`: drive `din` with `dout_ovf = 0`. Any pending own result moves to or stays in a one-entry hold buffer.
  - Else if the hold buffer is full: drive the hold buffer.
  - Else if `res_vld`: drive `res`.
  - A new `res_vld` when no output slot is free and the hold buffer is full drops the new result and sets `err_drop`; the older held result is kept.
  - The held result and a newer `res` are therefore emitted oldest first.

## Timing
- **Reset values:** `dout=0`, `dout_vld=0`, `dout_ovf=0`, `nmap=0`, `nmap_vld=0`, `busy=0`, `err_drop=0`; `cnt`, `acc` and all hold/result stages cleared.
- **Reset mid-window:** the partial sum is discarded; the next `mac_en` starts a new window.
- **Latency:** last MAC in cycle t gives `res_vld` in t+1 and `dout_vld` in t+2 when `din_vld` is low at t+1. Each cycle of upstream `din_vld` delays the own result by one further cycle.
- **`din` pass-through latency:** 1 cycle.
- **`nmap` latency:** 1 cycle.
- **`busy`:** high from the cycle after the first MAC until the cycle after the last MAC. It stays low throughout when `len=1`.
- **`len=1`:** produces back-to-back results, one per `mac_en` cycle.
- **`cfg_len`/`cfg_relu` changes mid-window** have no effect until the next window.

## Test plan
Settings for all scenarios: DATA_W=8, FRAC_W=3, ACC_W=24 (1.0 = 8).
- **Basic:** `cfg_len=3`, `bias=8`, 3 MACs of `imap=16`, `iweight=8` -> one `dout_vld` pulse 2 cycles after the last MAC, `dout=56`, `dout_ovf=0`; `busy` high for 2 cycles.
- **Rounding and ReLU:** `cfg_len=1`, `bias=0`.
  - `imap=4`, `iweight=1` -> `dout=1`.
  - `imap=3`, `iweight=1` -> `dout=0`.
  - `imap=-16`, `iweight=8` -> `dout=0xF0` with `cfg_relu=0`, `0x00` with `cfg_relu=1`.
- **Saturation:** `cfg_len=25`, `bias=0`, `imap=iweight=127` -> `dout=127`, `dout_ovf=1`; with `imap=-128`, `iweight=127` -> `dout=-128` (0x80), `dout_ovf=1`.
- **Collision:** `din=0x55` with `din_vld` high for 3 cycles covering the own `res_vld` cycle -> three 0x55 words, then the own result on the next cycle; `err_drop=0`.
- **Overflow of the hold buffer:** `cfg_len=1`, `mac_en` held high continuously with `din_vld` high for 4 cycles -> `err_drop` sets. The first held result is emitted once `din_vld` falls. `err_drop` stays 1 until `rst_cal`.
- **Gaps and reset:** `cfg_len=5` with `mac_en` toggling 1/0 -> same result as contiguous. Assert `rst_cal` after 3 taps -> all outputs 0. A following 5-tap window yields the result of those 5 taps only.
